// File: rtl/skein_pkg.sv
// Shared Skein-1024 round definitions: word/state widths, lane layout,
// the two rotation-constant sets and the lane permutations used by every mix.
package skein_pkg;

    localparam int WORD_W  = 64;
    localparam int STATE_W = 1024;
    localparam int LANES   = 8;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [LANES-1:0] half_t;

    // Rows are indexed by mix position within a round group, columns by lane.
    localparam int unsigned ROT_EVEN [4][8] = '{
        '{24, 13,  8, 47,  8, 17, 22, 37},
        '{38, 19, 10, 55, 49, 18, 23, 52},
        '{33,  4, 51, 13, 34, 41, 59, 17},
        '{ 5, 20, 48, 41, 47, 28, 16, 25}
    };

    localparam int unsigned ROT_ODD [4][8] = '{
        '{41,  9, 37, 31, 12, 47, 44, 30},
        '{16, 34, 56, 51,  4, 53, 42, 41},
        '{31, 44, 47, 46, 19, 42, 44, 25},
        '{ 9, 48, 35, 52, 23, 31, 37, 20}
    };

    localparam int unsigned PERM_E [8] = '{0, 1, 3, 2, 5, 6, 7, 4};
    localparam int unsigned PERM_O [8] = '{4, 6, 5, 7, 3, 1, 2, 0};

    function automatic int unsigned idx64(input int unsigned w);
        return w * WORD_W;
    endfunction

    // A zero rotation shifts right by the full width, which yields 0, so x is returned intact.
    function automatic word_t rotl64(input word_t x, input int unsigned r);
        return (x << r) | (x >> (WORD_W - r));
    endfunction

endpackage

// File: rtl/skein_mix8_rt.sv
// One combinational Skein-1024 mix over the even/odd lane halves, with the
// rotation set (even or odd constants) selected per beat at runtime.
module skein_mix8_rt
    import skein_pkg::*;
#(
    parameter int unsigned K = 0
) (
    input  half_t i_e,
    input  half_t i_o,
    input  logic  i_odd,
    output half_t o_e,
    output half_t o_o
);

    localparam int unsigned KS = K % 4;

    half_t w_t;
    half_t w_rot;

    // Each odd lane rotates by its own constant before being permuted with the sums.
    always_comb begin
        w_t   = '0;
        w_rot = '0;
        o_e   = '0;
        o_o   = '0;
        for (int i = 0; i < LANES; i++) begin
            w_t[i]   = i_e[i] + i_o[i];
            w_rot[i] = rotl64(i_o[i], i_odd ? ROT_ODD[KS][i] : ROT_EVEN[KS][i]);
        end
        for (int j = 0; j < LANES; j++) begin
            o_e[j] = w_t[PERM_E[j]];
            o_o[j] = w_t[PERM_O[j]] ^ w_rot[PERM_O[j]];
        end
    end

endmodule

// File: rtl/skein_round_pipe.sv
// Skein-1024 round pipeline: NUM_ROUNDS mixes with selectable inter-mix
// registers, lock-step ready/valid advance and a tag carried with each beat.
module skein_round_pipe
    import skein_pkg::*;
#(
    parameter int          NUM_ROUNDS = 4,
    parameter logic [7:0]  PIPE_MASK  = 8'b0000_0111,
    parameter int          TAG_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_odd,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag
);

    typedef struct packed {
        logic             valid;
        logic             odd;
        logic [TAG_W-1:0] tag;
        half_t            e;
        half_t            o;
    } stage_t;

    stage_t w_split;
    stage_t w_mixIn  [NUM_ROUNDS];
    stage_t w_mixOut [NUM_ROUNDS];

    logic               w_adv;
    logic [STATE_W-1:0] w_merged;
    logic               r_outValid;
    logic [STATE_W-1:0] r_outData;
    logic [TAG_W-1:0]   r_outTag;

    assign w_adv    = ~r_outValid | out_ready;
    assign in_ready = w_adv;

    always_comb begin
        w_split       = '0;
        w_split.valid = in_valid;
        w_split.odd   = in_odd;
        w_split.tag   = in_tag;
        for (int i = 0; i < LANES; i++) begin
            w_split.e[i] = in_data[idx64(2 * i) +: WORD_W];
            w_split.o[i] = in_data[idx64(2 * i + 1) +: WORD_W];
        end
    end

    for (genvar k = 0; k < NUM_ROUNDS; k++) begin : g_round
        logic  w_oddSel;
        half_t w_e;
        half_t w_o;

        if (k == 0) begin : g_first
            assign w_mixIn[0] = w_split;
        end

        // An 8-round pipe runs the even group then the odd group regardless of in_odd.
        assign w_oddSel = (NUM_ROUNDS == 8) ? (k >= 4) : w_mixIn[k].odd;

        skein_mix8_rt #(.K(k)) u_mix (
            .i_e   (w_mixIn[k].e),
            .i_o   (w_mixIn[k].o),
            .i_odd (w_oddSel),
            .o_e   (w_e),
            .o_o   (w_o)
        );

        assign w_mixOut[k] = {w_mixIn[k].valid, w_mixIn[k].odd, w_mixIn[k].tag, w_e, w_o};

        if (k < NUM_ROUNDS - 1) begin : g_link
            if (PIPE_MASK[k]) begin : g_reg
                stage_t r_stage;

                // Payload only loads under a valid beat; bubbles just clear the valid bit.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_stage.valid <= 1'b0;
                    end else if (w_adv) begin
                        r_stage.valid <= w_mixOut[k].valid;
                        if (w_mixOut[k].valid) begin
                            r_stage.odd <= w_mixOut[k].odd;
                            r_stage.tag <= w_mixOut[k].tag;
                            r_stage.e   <= w_mixOut[k].e;
                            r_stage.o   <= w_mixOut[k].o;
                        end
                    end
                end

                assign w_mixIn[k+1] = r_stage;
            end else begin : g_wire
                assign w_mixIn[k+1] = w_mixOut[k];
            end
        end
    end

    always_comb begin
        w_merged = '0;
        for (int i = 0; i < LANES; i++) begin
            w_merged[idx64(2 * i) +: WORD_W]     = w_mixOut[NUM_ROUNDS-1].e[i];
            w_merged[idx64(2 * i + 1) +: WORD_W] = w_mixOut[NUM_ROUNDS-1].o[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outTag   <= '0;
        end else if (w_adv) begin
            r_outValid <= w_mixOut[NUM_ROUNDS-1].valid;
            if (w_mixOut[NUM_ROUNDS-1].valid) begin
                r_outData <= w_merged;
                r_outTag  <= w_mixOut[NUM_ROUNDS-1].tag;
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_tag   = r_outTag;

endmodule
